// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary to packed-BCD converter (double dabble).
// It performs one shift per clock behind a start/busy/done handshake. The
// last result is held on bcd/ovf, so a downstream display never shows
// partial values. Results above 10^DIGITS-1 saturate to all nines and set ovf.
// Optional build macro: BIN_TO_BCD_LZ_BLANK_EN enables the registered
// leading-zero blank mask on lz_mask. When it is undefined, lz_mask is tied to 0.

module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 27,
  parameter int DIGITS   = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     lz_mask
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [IN_WIDTH-1:0] r_shreg;
  logic [BCD_W-1:0]    r_scratch;
  logic [CNT_W-1:0]    r_count;
  logic                r_sticky;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic [BCD_W-1:0]    r_bcd;

  logic [BCD_W-1:0]    w_adj;
  logic [BCD_W-1:0]    w_nextScratch;
  logic [IN_WIDTH-1:0] w_nextShreg;
  logic                w_nextSticky;
  logic [BCD_W-1:0]    w_result;
  logic                w_finish;

  // Add 3 to every scratch digit of 5 or more, so the next shift carries correctly into the digit above
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // A 1 leaving the top digit means the prefix already exceeds the digit range, so the result saturates
  assign w_nextScratch = {w_adj[BCD_W-2:0], r_shreg[IN_WIDTH-1]};
  assign w_nextShreg   = {r_shreg[IN_WIDTH-2:0], 1'b0};
  assign w_nextSticky  = r_sticky | w_adj[BCD_W-1];
  assign w_result      = w_nextSticky ? {DIGITS{4'h9}} : w_nextScratch;
  assign w_finish      = (r_state == SHIFT) && (r_count == LAST_CNT);

  // Control FSM with registered handshake outputs; bcd/ovf load only on the edge entering DONE
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_sticky  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_shreg   <= bin;
            r_scratch <= '0;
            r_sticky  <= 1'b0;
            r_count   <= '0;
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= w_nextScratch;
          r_shreg   <= w_nextShreg;
          r_sticky  <= w_nextSticky;
          r_count   <= r_count + 1'b1;
          if (w_finish) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_bcd   <= w_result;
            r_ovf   <= w_nextSticky;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef BIN_TO_BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] r_lzMask;
  logic [DIGITS-1:0] w_lzMask;
  logic              w_zeroRun;

  // Walk down from the top digit; a digit is blanked while it and every digit above it are zero
  always_comb begin
    w_lzMask  = '0;
    w_zeroRun = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zeroRun   = w_zeroRun & (w_result[4*i +: 4] == 4'd0);
      w_lzMask[i] = w_zeroRun;
    end
  end

  // The mask is registered alongside bcd so the two always describe the same result
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_lzMask <= '0;
    end else if (w_finish) begin
      r_lzMask <= w_lzMask;
    end
  end

  assign lz_mask = r_lzMask;
`else
  assign lz_mask = '0;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign bcd  = r_bcd;

endmodule
